loop_count_ctrl: RTL
====================

// Module: loop_count_ctrl
// PURPOSE
//   Upstream sequencer for the ripple decrement counter (INC_OR_DEC=1).
//   Accepts a repeat command carrying a beat count, loads the counter through its set path,
//   then issues one beat per downstream valid/ready handshake.
//   Emits one counter trigger pulse per accepted beat and signals done when the count is exhausted or aborted.
//   Keeps a synchronous shadow of the remaining count; it does not read the counter's q.
// PARAMETERS
//   WIDTH  3  width of beat count, counter set value and shadow remaining count
// PORTS
//   clk          in   1      single clock; all state changes on rising edge
//   reset        in   1      synchronous, active-high reset
//   cmd_valid    in   1      repeat command present
//   cmd_ready    out  1      block can accept a command (IDLE and not in reset)
//   cmd_count    in   WIDTH  number of beats to issue; 0 = no beats
//   abort        in   1      terminate the current command early
//   beat_valid   out  1      a beat is offered downstream
//   beat_ready   in   1      downstream accepts the beat
//   beat_last    out  1      offered beat is the final one (remaining==1)
//   remaining    out  WIDTH  shadow count of beats not yet accepted
//   cnt_set      out  1      one-cycle load strobe to the counter
//   cnt_set_val  out  WIDTH  load value; valid while cnt_set=1, else 0
//   cnt_trig     out  1      one-cycle decrement pulse, registered
//   done         out  1      one-cycle completion pulse
//   aborted      out  1      qualifies done: 1 = ended by abort; 0 outside done
// BEHAVIOUR
//   Reset (sync, reset=1 at an edge):
//     - state=IDLE, remaining=0, cnt_set=0, cnt_set_val=0, cnt_trig=0, done=0, aborted=0.
//     - cmd_ready is forced 0 while reset is high.
//     - Reset mid-operation drops the command silently: no done, no further trig.
//   FSM IDLE -> LOAD -> RUN -> DONE -> IDLE:
//     IDLE
//       - cmd_ready=1.
//       - cmd_valid at edge T with cmd_count!=0: go to LOAD; remaining<=cmd_count.
//       - cmd_valid at T with cmd_count==0: go to DONE; aborted stays 0.
//       - abort in IDLE is ignored.
//     LOAD (exactly 1 cycle)
//       - cnt_set=1, cnt_set_val=remaining; cmd_ready=0.
//       - Go to RUN, or to DONE with aborted=1 if abort=1.
//     RUN
//       - beat_valid=1; beat_last=(remaining==1).
//       - Accept: beat_valid & beat_ready at edge E.
//         remaining<=remaining-1 and cnt_trig=1 during cycle E+1.
//       - Accept with remaining==1: go to DONE, aborted=0.
//       - abort without accept: go to DONE, aborted=1; remaining holds.
//       - abort with accept in the same cycle: the beat counts (remaining-1, trig issued).
//         Then DONE with aborted=1, unless it was the last beat, in which case aborted=0.
//     DONE (exactly 1 cycle)
//       - done=1; cmd_ready=0; beat_valid=0.
//       - Go to IDLE. A new command is accepted in the cycle after done at the earliest.
//   Latency
//     - Command accepted at T: cnt_set high in cycle T+1, first beat_valid in T+2.
//     - count==0: done high in T+1.
//     - N beats with beat_ready held high: done in cycle T+2+N.
//   Invariants
//     - Number of cnt_trig pulses per command equals the number of accepted beats.
//     - remaining never wraps below 0.
//     - cnt_set and cnt_trig are never high in the same cycle.
//     - Only beat_valid, beat_last and cmd_ready are combinational from state; all others are registered.
//   Arithmetic
//     - Unsigned, WIDTH bits.
//     - cmd_count=2^WIDTH-1 (7 at default) is the maximum; no saturation is needed.
// TESTING
//   1. Reset, then cmd_count=3, beat_ready=1 -> cnt_set_val=3 at T+1; 3 beats, beat_last on 3rd;
//      3 cnt_trig pulses; done at T+5, aborted=0.
//   2. cmd_count=0 -> no cnt_set, no beat_valid; done=1 at T+1, aborted=0; cmd_ready=1 at T+2.
//   3. cmd_count=5, beat_ready toggling 1,0,1,0 -> beat_valid held across stalls;
//      remaining 5,4,4,3,3; trig only after accepts.
//   4. cmd_count=4, abort after 2 accepts -> done with aborted=1; remaining=2; exactly 2 trig pulses.
//   5. cmd_count=1, abort and beat_ready together -> beat accepted, 1 trig, done with aborted=0.
//   6. cmd_count=7, reset asserted in RUN after 3 beats -> all outputs 0 next cycle; no done;
//      cmd_ready=1 after reset is released.

Source files
------------

// File: rtl/loop_count_ctrl.sv
// Repeat-command sequencer for a decrement counter: loads the count,
// then issues one beat and one counter trigger per accepted handshake.
module loop_count_ctrl #(
   parameter int WIDTH = 3
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [WIDTH-1:0] cmd_count,
   input  logic             abort,
   output logic             beat_valid,
   input  logic             beat_ready,
   output logic             beat_last,
   output logic [WIDTH-1:0] remaining,
   output logic             cnt_set,
   output logic [WIDTH-1:0] cnt_set_val,
   output logic             cnt_trig,
   output logic             done,
   output logic             aborted
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_LOAD,
      S_RUN,
      S_DONE
   } state_e;

   localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

   state_e           state_q, state_d;
   logic [WIDTH-1:0] rem_q, rem_d;
   logic [WIDTH-1:0] setv_q, setv_d;
   logic             set_q, set_d;
   logic             trig_q, trig_d;
   logic             done_q, done_d;
   logic             abt_q, abt_d;
   logic             accept;

   assign accept = (state_q == S_RUN) && beat_ready;

   always_comb begin
      state_d = state_q;
      rem_d   = rem_q;
      setv_d  = '0;
      set_d   = 1'b0;
      trig_d  = 1'b0;
      done_d  = 1'b0;
      abt_d   = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            if (cmd_valid) begin
               rem_d = cmd_count;
               if (cmd_count != '0) begin
                  state_d = S_LOAD;
                  set_d   = 1'b1;
                  setv_d  = cmd_count;
               end else begin
                  state_d = S_DONE;
                  done_d  = 1'b1;
               end
            end
         end
         S_LOAD: begin
            if (abort) begin
               state_d = S_DONE;
               done_d  = 1'b1;
               abt_d   = 1'b1;
            end else begin
               state_d = S_RUN;
            end
         end
         S_RUN: begin
            if (accept) begin
               rem_d  = rem_q - ONE;
               trig_d = 1'b1;
            end
            // A last beat accepted alongside abort still completes normally.
            if (accept && rem_q == ONE) begin
               state_d = S_DONE;
               done_d  = 1'b1;
            end else if (abort) begin
               state_d = S_DONE;
               done_d  = 1'b1;
               abt_d   = 1'b1;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_IDLE;
         rem_q   <= '0;
         setv_q  <= '0;
         set_q   <= 1'b0;
         trig_q  <= 1'b0;
         done_q  <= 1'b0;
         abt_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         rem_q   <= rem_d;
         setv_q  <= setv_d;
         set_q   <= set_d;
         trig_q  <= trig_d;
         done_q  <= done_d;
         abt_q   <= abt_d;
      end
   end

   assign cmd_ready   = (state_q == S_IDLE) && !reset;
   assign beat_valid  = (state_q == S_RUN);
   assign beat_last   = beat_valid && (rem_q == ONE);
   assign remaining   = rem_q;
   assign cnt_set     = set_q;
   assign cnt_set_val = setv_q;
   assign cnt_trig    = trig_q;
   assign done        = done_q;
   assign aborted     = abt_q;

endmodule
